// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALU operation classes, R-type
// function codes and the multiplier FSM state type.
package ex_pkg;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_RTYPE = 3'b010;
  localparam logic [2:0] ALUOP_AND   = 3'b011;
  localparam logic [2:0] ALUOP_OR    = 3'b100;
  localparam logic [2:0] ALUOP_SLT   = 3'b101;

  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;
  localparam logic [5:0] FUNCT_MULT = 6'b011000;
  localparam logic [5:0] FUNCT_MFHI = 6'b010000;
  localparam logic [5:0] FUNCT_MFLO = 6'b010010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } mult_state_e;

endpackage

// File: rtl/ex_stage_booth_mult.sv
// Sequential radix-2 Booth multiplier (signed), one step per cycle, with the
// HI/LO result registers. The accumulator is one bit wider than the operands.
module booth_mult
  import ex_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  mult_state_e      state_q;
  logic [WIDTH:0]   m_q, acc_q, acc_sum, acc_d;
  logic [WIDTH-1:0] q_q, q_d, hi_q, lo_q;
  logic             q1_q, q1_d;
  logic [CW-1:0]    count_q;

  // One Booth step: conditional add/sub of M, then arithmetic shift of {ACC,Q,q-1}.
  always_comb begin
    acc_sum = acc_q;
    case ({q_q[0], q1_q})
      2'b10:   acc_sum = acc_q - m_q;
      2'b01:   acc_sum = acc_q + m_q;
      default: acc_sum = acc_q;
    endcase
    {acc_d, q_d, q1_d} = $signed({acc_sum, q_q, q1_q}) >>> 1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            m_q     <= {multiplicand[WIDTH-1], multiplicand};
            acc_q   <= '0;
            q_q     <= multiplier;
            q1_q    <= 1'b0;
            count_q <= '0;
            state_q <= MUL;
          end
        end
        MUL: begin
          acc_q   <= acc_d;
          q_q     <= q_d;
          q1_q    <= q1_d;
          count_q <= count_q + 1'b1;
          if (count_q == CW'(WIDTH - 1)) begin
            hi_q    <= acc_d[WIDTH-1:0];
            lo_q    <= q_d;
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: combinational ALU, branch-target adder, destination select,
// and the stall interface around the sequential Booth multiplier.
module ex_stage
  import ex_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] ReadData1,
  input  logic [WIDTH-1:0] ReadData2,
  input  logic [WIDTH-1:0] SignExtendImmediate,
  input  logic             ALUSrc,
  input  logic             RegDst,
  input  logic [2:0]       ALUOp,
  input  logic [5:0]       funct,
  input  logic [4:0]       rd,
  input  logic [4:0]       rt,
  input  logic [WIDTH-1:0] nextPC,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic [WIDTH-1:0] BranchTarget,
  output logic [4:0]       WriteReg,
  output logic [WIDTH-1:0] StoreData,
  output logic             Stall,
  output logic             Busy
);

  logic [WIDTH-1:0] op_b, hi, lo, result;
  logic             is_mult, start, mul_busy, mul_done, lt;

  assign op_b    = ALUSrc ? SignExtendImmediate : ReadData2;
  assign lt      = $signed(ReadData1) < $signed(op_b);
  assign is_mult = (ALUOp == ALUOP_RTYPE) && (funct == FUNCT_MULT);
  // A mult held in ID_EX during DONE must not relaunch, hence the busy gate.
  assign start   = is_mult & ~mul_busy & ~rst;

  booth_mult #(.WIDTH(WIDTH)) u_mult (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (ReadData1),
    .multiplier   (ReadData2),
    .busy         (mul_busy),
    .done         (mul_done),
    .hi           (hi),
    .lo           (lo)
  );

  always_comb begin
    result = '0;
    case (ALUOp)
      ALUOP_ADD: result = ReadData1 + op_b;
      ALUOP_SUB: result = ReadData1 - op_b;
      ALUOP_AND: result = ReadData1 & op_b;
      ALUOP_OR:  result = ReadData1 | op_b;
      ALUOP_SLT: result = {{(WIDTH-1){1'b0}}, lt};
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD:  result = ReadData1 + op_b;
          FUNCT_SUB:  result = ReadData1 - op_b;
          FUNCT_AND:  result = ReadData1 & op_b;
          FUNCT_OR:   result = ReadData1 | op_b;
          FUNCT_SLT:  result = {{(WIDTH-1){1'b0}}, lt};
          FUNCT_MULT: result = lo;
          FUNCT_MFHI: result = hi;
          FUNCT_MFLO: result = lo;
          default:    result = '0;
        endcase
      end
      default: result = '0;
    endcase
  end

  assign ALUResult    = result;
  assign Zero         = (result == '0);
  assign BranchTarget = nextPC + (SignExtendImmediate << 2);
  assign WriteReg     = RegDst ? rd : rt;
  assign StoreData    = ReadData2;
  assign Stall        = start | (mul_busy & ~mul_done);
  assign Busy         = mul_busy;

endmodule
